instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter P_SIZE, default 6, program address width.
REQ-002 SHALL have parameter I_SIZE, default 16, instruction width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pcIn  input  P_SIZE  current address from program counter.
REQ-006 SHALL have port romAddr  output  P_SIZE  program ROM address (synchronous ROM, 1-cycle read).
REQ-007 SHALL have port romData  input  I_SIZE  ROM read data.
REQ-008 SHALL have port zeroFlag  input  1  ALU zero flag, sampled in EXEC.
REQ-009 SHALL have port goIn  input  1  release for WAIT instruction.
REQ-010 SHALL have port irOut  output  I_SIZE  instruction register.
REQ-011 SHALL have port irValid  output  1  irOut valid for decoder.
REQ-012 SHALL have port irReady  input  1  decoder accepts irOut.
REQ-013 SHALL have ports inc, branchAbs, branchRel  output  1 each  PC control pulses.
REQ-014 SHALL have port branchAddressOut  output  P_SIZE  branch target/offset to PC.
REQ-015 SHALL have port halted  output  1  HALT state indicator.
REQ-016 SHALL have port retireCount  output  16  retired-instruction count.

Function
REQ-017 SHALL implement FSM states FETCH, DECODE, EXEC, WAIT, HALT; opcode = irOut[I_SIZE-1:I_SIZE-4].
REQ-018 FETCH: romAddr = pcIn; next state DECODE unconditionally.
REQ-019 DECODE: irOut <= romData at end of cycle; next state EXEC.
REQ-020 EXEC: irValid = 1; hold EXEC, irOut stable, all PC controls 0 while irReady = 0.
REQ-021 EXEC with irReady = 1: exactly one action for one cycle -- JMP (4'hE): branchAbs; BEQ (4'hC) and zeroFlag: branchRel; BNE (4'hD) and !zeroFlag: branchRel; WAIT (4'hA): none, go WAIT; HALT (4'hF): none, go HALT; all other cases: inc; then FETCH unless WAIT/HALT.
REQ-022 branchAddressOut = irOut[P_SIZE-1:0] at all times; relative offset two's complement, wrap modulo 2^P_SIZE performed by PC.
REQ-023 inc, branchAbs, branchRel mutually exclusive; never asserted outside EXEC/WAIT.
REQ-024 WAIT: exit on first cycle goIn = 1 (including first WAIT cycle): assert inc that cycle, go FETCH; else hold.
REQ-025 HALT: halted = 1, irValid = 0, no PC controls; exit only by reset.
REQ-026 Latency: 3 cycles per unstalled instruction; new pcIn used in FETCH cycle after PC update.
REQ-027 romAddr = pcIn in all states (don't-care outside FETCH, fixed for determinism).

Reset
REQ-028 rst SHALL asynchronously force state FETCH, irOut = 0, irValid = 0, halted = 0, retireCount = 0, all PC controls 0, including mid-EXEC/WAIT/HALT.
REQ-029 First instruction after rst deasserts SHALL be fetched from pcIn in the first clock cycle.

Configuration
REQ-030 With RETIRE_COUNT_EN defined, retireCount SHALL increment on each EXEC handshake (irValid & irReady) and each WAIT exit, saturating at 16'hFFFF.
REQ-031 Without RETIRE_COUNT_EN, retireCount SHALL be constant 0 and no counter logic synthesised.

Structure
REQ-032 Package picomips_fetch_pkg SHALL hold opcode constants (OP_JMP, OP_BEQ, OP_BNE, OP_WAIT, OP_HALT), the state enum type and opcode field width.
REQ-033 Counter SHALL be sub-module retire_counter, instantiated only under RETIRE_COUNT_EN.

Verification
REQ-034 pcIn = 0, ROM[0] = 16'h0000, irReady = 1 -> irValid in cycle 3, irOut = 16'h0000, inc pulse in same cycle, FETCH in cycle 4.
REQ-035 ROM word 16'hE015 (JMP) -> branchAbs one cycle, branchAddressOut = 6'h15, inc = 0.
REQ-036 BEQ 16'hC03E with zeroFlag = 1 -> branchRel, offset 6'h3E (-2); zeroFlag = 0 -> inc only; BNE mirror.
REQ-037 irReady low 5 cycles in EXEC -> irValid high, irOut stable, no PC pulse; pulse in cycle irReady rises.
REQ-038 WAIT 16'hA000, goIn low 4 cycles then high -> inc once on goIn cycle, retireCount +1 (macro on), 0 (macro off).
REQ-039 HALT 16'hF000 then rst pulse mid-HALT -> halted 1 until rst, all outputs 0 asynchronously, refetch from pcIn.

Source files
------------

// File: rtl/picomips_fetch_pkg.sv
// Shared definitions for the picoMIPS instruction fetch unit: opcode values,
// the fetch FSM state type and the opcode field width.
package picomips_fetch_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_JMP  = 4'hE;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'hC;
  localparam logic [OP_W-1:0] OP_BNE  = 4'hD;
  localparam logic [OP_W-1:0] OP_WAIT = 4'hA;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WAIT,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/retire_counter.sv
// Saturating event counter for retired instructions. Only instantiated when
// RETIRE_COUNT_EN is defined.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (en && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch/decode/execute sequencer for picoMIPS. Optional retired-instruction
// counter enabled with the RETIRE_COUNT_EN macro.
module instruction_fetch
  import picomips_fetch_pkg::*;
#(
  parameter int P_SIZE = 6,
  parameter int I_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [P_SIZE-1:0] pcIn,
  output logic [P_SIZE-1:0] romAddr,
  input  logic [I_SIZE-1:0] romData,
  input  logic              zeroFlag,
  input  logic              goIn,
  output logic [I_SIZE-1:0] irOut,
  output logic              irValid,
  input  logic              irReady,
  output logic              inc,
  output logic              branchAbs,
  output logic              branchRel,
  output logic [P_SIZE-1:0] branchAddressOut,
  output logic              halted,
  output logic [15:0]       retireCount
);

  fetch_state_t    state;
  logic [OP_W-1:0] opcode;
  logic            handshake;
  logic            waitExit;

  assign opcode           = irOut[I_SIZE-1 -: OP_W];
  assign romAddr          = pcIn;
  assign branchAddressOut = irOut[P_SIZE-1:0];
  assign irValid          = (state == ST_EXEC);
  assign halted           = (state == ST_HALT);
  assign handshake        = irValid & irReady;
  assign waitExit         = (state == ST_WAIT) & goIn;

  // PC controls react in the same cycle as the handshake / go release.
  always_comb begin
    inc       = 1'b0;
    branchAbs = 1'b0;
    branchRel = 1'b0;
    if (handshake) begin
      case (opcode)
        OP_JMP:           branchAbs = 1'b1;
        OP_BEQ:           if (zeroFlag) branchRel = 1'b1; else inc = 1'b1;
        OP_BNE:           if (!zeroFlag) branchRel = 1'b1; else inc = 1'b1;
        OP_WAIT, OP_HALT: ;
        default:          inc = 1'b1;
      endcase
    end else if (waitExit) begin
      inc = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      irOut <= '0;
    end else begin
      case (state)
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          irOut <= romData;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (irReady) begin
            if (opcode == OP_WAIT)      state <= ST_WAIT;
            else if (opcode == OP_HALT) state <= ST_HALT;
            else                        state <= ST_FETCH;
          end
        end
        ST_WAIT:   if (goIn) state <= ST_FETCH;
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_FETCH;
      endcase
    end
  end

`ifdef RETIRE_COUNT_EN
  retire_counter #(.CNT_W(16)) u_retire_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (handshake | waitExit),
    .count (retireCount)
  );
`else
  assign retireCount = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed plus randomized bench for instruction_fetch with a per-instruction
// reference model of the expected PC pulses, outputs and retire count.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pcIn;
  logic [5:0]  romAddr;
  logic [15:0] romData;
  logic        zeroFlag;
  logic        goIn;
  logic [15:0] irOut;
  logic        irValid;
  logic        irReady;
  logic        inc;
  logic        branchAbs;
  logic        branchRel;
  logic [5:0]  branchAddressOut;
  logic        halted;
  logic [15:0] retireCount;

  logic [15:0] rom [64];
  int          total = 0;
  int          bad   = 0;
  int          expCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) romData <= rom[romAddr];

  instruction_fetch #(.P_SIZE(6), .I_SIZE(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .pcIn             (pcIn),
    .romAddr          (romAddr),
    .romData          (romData),
    .zeroFlag         (zeroFlag),
    .goIn             (goIn),
    .irOut            (irOut),
    .irValid          (irValid),
    .irReady          (irReady),
    .inc              (inc),
    .branchAbs        (branchAbs),
    .branchRel        (branchRel),
    .branchAddressOut (branchAddressOut),
    .halted           (halted),
    .retireCount      (retireCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {inc, branchAbs, branchRel} when an instruction is accepted.
  function automatic logic [2:0] exp_pulse(input logic [15:0] w, input logic z);
    case (w[15:12])
      4'hE:       return 3'b010;
      4'hC:       return z ? 3'b001 : 3'b100;
      4'hD:       return z ? 3'b100 : 3'b001;
      4'hA, 4'hF: return 3'b000;
      default:    return 3'b100;
    endcase
  endfunction

  function automatic void retire();
`ifdef RETIRE_COUNT_EN
    if (expCount < 16'hFFFF) expCount++;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH to completion; HALT ends with a reset pulse.
  task automatic run_instr(input logic [5:0] pc, input logic [15:0] w, input logic z,
                           input int stall, input int goDelay);
    pcIn = pc;
    rom[pc] = w;
    zeroFlag = z;
    irReady = 1'b0;
    goIn = 1'b0;
    @(negedge clk);
    chk("fetch_romAddr", 32'(romAddr), 32'(pc));
    chk("fetch_pulses", 32'({inc, branchAbs, branchRel}), 32'd0);
    chk("fetch_irValid", 32'(irValid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("decode_irValid", 32'(irValid), 32'd0);
    chk("decode_pulses", 32'({inc, branchAbs, branchRel}), 32'd0);
    next_cycle();
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_irValid", 32'(irValid), 32'd1);
      chk("stall_irOut", 32'(irOut), 32'(w));
      chk("stall_pulses", 32'({inc, branchAbs, branchRel}), 32'd0);
      next_cycle();
    end
    irReady = 1'b1;
    @(negedge clk);
    chk("exec_irValid", 32'(irValid), 32'd1);
    chk("exec_irOut", 32'(irOut), 32'(w));
    chk("exec_branchAddr", 32'(branchAddressOut), 32'(w[5:0]));
    chk("exec_pulses", 32'({inc, branchAbs, branchRel}), 32'(exp_pulse(w, z)));
    chk("exec_halted", 32'(halted), 32'd0);
    retire();
    next_cycle();
    irReady = 1'b0;
    if (w[15:12] == 4'hA) begin
      for (int g = 0; g < goDelay; g++) begin
        @(negedge clk);
        chk("wait_pulses", 32'({inc, branchAbs, branchRel}), 32'd0);
        chk("wait_irValid", 32'(irValid), 32'd0);
        next_cycle();
      end
      goIn = 1'b1;
      @(negedge clk);
      chk("wait_exit_pulses", 32'({inc, branchAbs, branchRel}), 32'b100);
      retire();
      next_cycle();
      goIn = 1'b0;
    end else if (w[15:12] == 4'hF) begin
      for (int h = 0; h < 3; h++) begin
        goIn = 1'b1;
        irReady = 1'b1;
        @(negedge clk);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_irValid", 32'(irValid), 32'd0);
        chk("halt_pulses", 32'({inc, branchAbs, branchRel}), 32'd0);
        next_cycle();
      end
      goIn = 1'b0;
      irReady = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_irValid", 32'(irValid), 32'd0);
      chk("rst_irOut", 32'(irOut), 32'd0);
      chk("rst_retire", 32'(retireCount), 32'd0);
      expCount = 0;
      next_cycle();
      rst = 1'b0;
    end
    chk("retireCount", 32'(retireCount), 32'(expCount));
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    rst = 1'b1;
    pcIn = '0;
    zeroFlag = 1'b0;
    goIn = 1'b0;
    irReady = 1'b0;
    #1;
    chk("reset_irValid", 32'(irValid), 32'd0);
    chk("reset_irOut", 32'(irOut), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_pulses", 32'({inc, branchAbs, branchRel}), 32'd0);
    chk("reset_retire", 32'(retireCount), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    run_instr(6'h00, 16'h0000, 1'b0, 0, 0);
    run_instr(6'h01, 16'hE015, 1'b0, 0, 0);
    run_instr(6'h15, 16'hC03E, 1'b1, 0, 0);
    run_instr(6'h13, 16'hC03E, 1'b0, 0, 0);
    run_instr(6'h14, 16'hD03E, 1'b0, 0, 0);
    run_instr(6'h12, 16'hD03E, 1'b1, 0, 0);
    run_instr(6'h20, 16'h1234, 1'b0, 5, 0);
    run_instr(6'h21, 16'hA000, 1'b0, 0, 4);
    run_instr(6'h22, 16'hA000, 1'b1, 2, 0);
    run_instr(6'h23, 16'hF000, 1'b0, 0, 0);
    run_instr(6'h00, 16'h5A5A, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      w = 16'($urandom);
      run_instr(6'($urandom), w, 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
